// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with a 40-bit humidity/temperature frame on an open-drain line.
// Optional macro DHT11_RESP_ERR_INJ_EN adds err_inject, which flips the checksum LSB of the latched frame.
module dht11_responder #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned START_MIN_US = 18000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rh_int,
  input  logic [7:0] rh_dec,
  input  logic [7:0] t_int,
  input  logic [7:0] t_dec,
`ifdef DHT11_RESP_ERR_INJ_EN
  input  logic       err_inject,
`endif
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] state,
  inout  wire        dht11_io
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned US_NEED  = (START_MIN_US > 80) ? START_MIN_US : 80;
  localparam int unsigned US_W     = $clog2(US_NEED + 1);

  // Terminal counts are duration-1: a state is left on the tick that completes its last microsecond.
  localparam logic [US_W-1:0] START_US = US_W'(START_MIN_US);
  localparam logic [US_W-1:0] T_WAIT   = US_W'(30 - 1);
  localparam logic [US_W-1:0] T_RESP   = US_W'(80 - 1);
  localparam logic [US_W-1:0] T_BLOW   = US_W'(50 - 1);
  localparam logic [US_W-1:0] T_ZERO   = US_W'(26 - 1);
  localparam logic [US_W-1:0] T_ONE    = US_W'(70 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HOST_LOW  = 4'd1,
    WAIT_REL  = 4'd2,
    RESP_LOW  = 4'd3,
    RESP_HIGH = 4'd4,
    BIT_LOW   = 4'd5,
    BIT_HIGH  = 4'd6,
    END_LOW   = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t            state_q, state_nx;
  logic [1:0]        sync_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [39:0]       shreg;
  logic [5:0]        bit_cnt;
  logic              drive_low;
  logic              line_s, tick, inj;
  logic              latch, shift, us_clr, drive_nx, busy_nx, done_nx;
  logic [7:0]        csum;
  logic [US_W-1:0]   bit_end;

`ifdef DHT11_RESP_ERR_INJ_EN
  assign inj = err_inject;
`else
  assign inj = 1'b0;
`endif

  assign line_s   = sync_q[1];
  assign tick     = (tick_cnt == TICK_LAST);
  assign csum     = rh_int + rh_dec + t_int + t_dec;
  assign bit_end  = shreg[39] ? T_ONE : T_ZERO;
  assign dht11_io = drive_low ? 1'b0 : 1'bz;
  assign state    = state_q;

  // Next-state and registered-output decode
  always_comb begin
    state_nx = state_q;
    latch    = 1'b0;
    shift    = 1'b0;
    us_clr   = 1'b0;
    drive_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    unique case (state_q)
      IDLE:      if (!line_s) state_nx = HOST_LOW;
      HOST_LOW:  if (line_s) begin
                   if (us_cnt >= START_US) begin
                     state_nx = WAIT_REL;
                     latch    = 1'b1;
                   end else begin
                     state_nx = IDLE;
                   end
                 end
      WAIT_REL:  if (tick && us_cnt == T_WAIT) state_nx = RESP_LOW;
      RESP_LOW:  if (tick && us_cnt == T_RESP) state_nx = RESP_HIGH;
      RESP_HIGH: if (tick && us_cnt == T_RESP) state_nx = BIT_LOW;
      BIT_LOW:   if (tick && us_cnt == T_BLOW) state_nx = BIT_HIGH;
      BIT_HIGH:  if (tick && us_cnt == bit_end) begin
                   if (bit_cnt == 6'd39) begin
                     state_nx = END_LOW;
                   end else begin
                     state_nx = BIT_LOW;
                     shift    = 1'b1;
                   end
                 end
      END_LOW:   if (tick && us_cnt == T_BLOW) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    us_clr   = (state_nx != state_q);
    drive_nx = (state_nx == RESP_LOW) || (state_nx == BIT_LOW) || (state_nx == END_LOW);
    busy_nx  = (state_nx >= WAIT_REL) && (state_nx <= END_LOW);
    done_nx  = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_nx;
      drive_low  <= drive_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
    end
  end

  // Synchronizer, microsecond timebase and frame shifter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= 2'b11;
      tick_cnt <= '0;
      us_cnt   <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
    end else begin
      sync_q <= {sync_q[0], dht11_io};
      if (us_clr) begin
        tick_cnt <= '0;
        us_cnt   <= '0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        if (tick && us_cnt != '1) us_cnt <= us_cnt + US_W'(1);
      end
      if (latch) begin
        shreg   <= {rh_int, rh_dec, t_int, t_dec, csum ^ {7'd0, inj}};
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= {shreg[38:0], 1'b0};
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: decodes the open-drain line into bit timings and frame bytes.
// Define DHT11_RESP_ERR_INJ_EN for both files to exercise the checksum error-injection build.
`timescale 1ns/1ps
module tb_dht11_responder;
  localparam int unsigned CLK_HZ       = 2_000_000;
  localparam int unsigned START_MIN_US = 100;
  localparam int          CPU          = 2;    // clocks per microsecond
  localparam int          SEG_MAX      = 400;  // bound on any single line segment, in clocks

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rh_int, rh_dec, t_int, t_dec;
`ifdef DHT11_RESP_ERR_INJ_EN
  logic       err_inject;
`endif
  logic       busy, frame_done;
  logic [3:0] state;
  logic       host_low;
  wire        dht11_io;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  pullup (dht11_io);
  assign dht11_io = host_low ? 1'b0 : 1'bz;

  dht11_responder #(.CLK_HZ(CLK_HZ), .START_MIN_US(START_MIN_US)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .rh_int     (rh_int),
    .rh_dec     (rh_dec),
    .t_int      (t_int),
    .t_dec      (t_dec),
`ifdef DHT11_RESP_ERR_INJ_EN
    .err_inject (err_inject),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .state      (state),
    .dht11_io   (dht11_io)
  );

  always #250 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic host_pulse(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * CPU) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Count consecutive negedge samples at the given level
  task automatic meas(input logic lvl, output int n);
    n = 0;
    while (dht11_io === lvl && n < SEG_MAX) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Decode one frame from the line; optionally change rh_int at the start of BIT_HIGH of bit chg_bit
  task automatic rx_frame(input int chg_bit, output logic [39:0] data, output logic to,
                          output int lat, output int rlow, output int rhigh, output int low_bad,
                          output int h0min, output int h0max, output int h1min, output int h1max,
                          output int elow);
    int n;
    data = '0; to = 1'b0; low_bad = 0;
    h0min = 9999; h0max = 0; h1min = 9999; h1max = 0;
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) to = 1'b1;
    lat = 0;
    while (dht11_io !== 1'b0 && lat < SEG_MAX) begin
      @(negedge clk);
      lat++;
    end
    meas(1'b0, rlow);
    meas(1'b1, rhigh);
    if (lat >= SEG_MAX || rlow >= SEG_MAX || rhigh >= SEG_MAX) to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      meas(1'b0, n);
      if (n < 98 || n > 102) low_bad++;
      if (i == chg_bit) rh_int = 8'd99;
      meas(1'b1, n);
      if (n >= SEG_MAX) to = 1'b1;
      data = {data[38:0], (n > 96)};
      if (n > 96) begin
        if (n < h1min) h1min = n;
        if (n > h1max) h1max = n;
      end else begin
        if (n < h0min) h0min = n;
        if (n > h0max) h0max = n;
      end
    end
    meas(1'b0, elow);
    if (elow >= SEG_MAX) to = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; host_low = 1'b0;
    rh_int = 8'd0; rh_dec = 8'd0; t_int = 8'd0; t_dec = 8'd0;
`ifdef DHT11_RESP_ERR_INJ_EN
    err_inject = 1'b0;
`endif
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    total++; if (dht11_io !== 1'b1) begin bad++; $display("FAIL reset_line: got %b want 1 (released)", dht11_io); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (state !== 4'd0) begin bad++; $display("FAIL post_reset_state: got %0d want 0", state); end
  endtask

  task automatic test_basic_frame;
    logic [39:0] d; logic to; int lat, rl, rh, lb, h0n, h0x, h1n, h1x, el, base;
    rh_int = 8'd55; rh_dec = 8'd0; t_int = 8'd24; t_dec = 8'd0;
    base = done_cnt;
    host_pulse(120);
    rx_frame(-1, d, to, lat, rl, rh, lb, h0n, h0x, h1n, h1x, el);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", to); end
    total++; if (d !== 40'h37_00_18_00_4F) begin bad++; $display("FAIL basic_data: got %h want 370018004f", d); end
    total++; if (lat < 58 || lat > 62) begin bad++; $display("FAIL basic_wait_rel: got %0d want 58..62 clk", lat); end
    total++; if (rl < 158 || rl > 162) begin bad++; $display("FAIL basic_resp_low: got %0d want 158..162 clk", rl); end
    total++; if (rh < 158 || rh > 162) begin bad++; $display("FAIL basic_resp_high: got %0d want 158..162 clk", rh); end
    total++; if (lb !== 0) begin bad++; $display("FAIL basic_bit_low: got %0d bad lows want 0", lb); end
    total++; if (h0n < 50 || h0x > 54) begin bad++; $display("FAIL basic_zero_high: got %0d..%0d want 50..54 clk", h0n, h0x); end
    total++; if (h1n < 138 || h1x > 142) begin bad++; $display("FAIL basic_one_high: got %0d..%0d want 138..142 clk", h1n, h1x); end
    total++; if (el < 98 || el > 102) begin bad++; $display("FAIL basic_end_low: got %0d want 98..102 clk", el); end
    repeat (6) @(negedge clk);
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - base); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL basic_state_after: got %0d want 0", state); end
  endtask

  task automatic test_short_pulse;
    int low_seen, busy_seen;
    low_seen = 0; busy_seen = 0;
    host_pulse(60);
    repeat (300) begin
      @(negedge clk);
      if (dht11_io === 1'b0) low_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    total++; if (low_seen !== 0) begin bad++; $display("FAIL short_line: got %0d low samples want 0", low_seen); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL short_busy: got %0d busy samples want 0", busy_seen); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL short_state: got %0d want 0", state); end
  endtask

  task automatic test_hold_inputs;
    logic [39:0] d; logic to; int lat, rl, rh, lb, h0n, h0x, h1n, h1x, el, base;
    rh_int = 8'd55; rh_dec = 8'd0; t_int = 8'd24; t_dec = 8'd0;
    base = done_cnt;
    host_pulse(120);
    rx_frame(3, d, to, lat, rl, rh, lb, h0n, h0x, h1n, h1x, el);
    total++; if (rh_int !== 8'd99) begin bad++; $display("FAIL hold_stim_applied: got %0d want 99", rh_int); end
    total++; if (d !== 40'h37_00_18_00_4F) begin bad++; $display("FAIL hold_data: got %h want 370018004f", d); end
    repeat (6) @(negedge clk);
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL hold_done_pulses: got %0d want 1", done_cnt - base); end
    rh_int = 8'd55;
  endtask

  task automatic test_reset_mid_frame;
    logic [39:0] d; logic to; int lat, rl, rh, lb, h0n, h0x, h1n, h1x, el, base, n, busy_seen;
    rh_int = 8'd55; rh_dec = 8'd0; t_int = 8'd24; t_dec = 8'd0;
    host_pulse(120);
    n = 0;
    while (dht11_io !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++; if (n >= 1000) begin bad++; $display("FAIL rstmid_resp_low_seen: got timeout want line low"); end
    repeat (20) @(negedge clk);
    #100 rst_n = 1'b0;
    #1;
    total++; if (dht11_io !== 1'b1) begin bad++; $display("FAIL rstmid_line: got %b want 1 (released)", dht11_io); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy === 1'b1 || dht11_io === 1'b0) busy_seen++;
    end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL rstmid_no_restart: got %0d active samples want 0", busy_seen); end
    base = done_cnt;
    host_pulse(120);
    rx_frame(-1, d, to, lat, rl, rh, lb, h0n, h0x, h1n, h1x, el);
    total++; if (d !== 40'h37_00_18_00_4F) begin bad++; $display("FAIL rstmid_data: got %h want 370018004f", d); end
    repeat (6) @(negedge clk);
    total++; if (done_cnt - base !== 1) begin bad++; $display("FAIL rstmid_done_pulses: got %0d want 1", done_cnt - base); end
  endtask

  task automatic test_all_ones;
    logic [39:0] d; logic to; int lat, rl, rh, lb, h0n, h0x, h1n, h1x, el;
    rh_int = 8'hFF; rh_dec = 8'hFF; t_int = 8'hFF; t_dec = 8'hFF;
    host_pulse(120);
    rx_frame(-1, d, to, lat, rl, rh, lb, h0n, h0x, h1n, h1x, el);
    total++; if (d !== 40'hFF_FF_FF_FF_FC) begin bad++; $display("FAIL ones_data: got %h want fffffffffc", d); end
    total++; if (h1n < 138 || h1x > 142) begin bad++; $display("FAIL ones_one_high: got %0d..%0d want 138..142 clk", h1n, h1x); end
    total++; if (h0n < 50 || h0x > 54) begin bad++; $display("FAIL ones_zero_high: got %0d..%0d want 50..54 clk", h0n, h0x); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_checksum;
    logic [39:0] d; logic to; int lat, rl, rh, lb, h0n, h0x, h1n, h1x, el;
    rh_int = 8'd1; rh_dec = 8'd2; t_int = 8'd3; t_dec = 8'd4;
    host_pulse(120);
    rx_frame(-1, d, to, lat, rl, rh, lb, h0n, h0x, h1n, h1x, el);
    total++; if (d !== 40'h01_02_03_04_0A) begin bad++; $display("FAIL csum_data: got %h want 010203040a", d); end
    repeat (6) @(negedge clk);
`ifdef DHT11_RESP_ERR_INJ_EN
    err_inject = 1'b1;
    host_pulse(120);
    rx_frame(-1, d, to, lat, rl, rh, lb, h0n, h0x, h1n, h1x, el);
    total++; if (d !== 40'h01_02_03_04_0B) begin bad++; $display("FAIL errinj_data: got %h want 010203040b", d); end
    err_inject = 1'b0;
    repeat (6) @(negedge clk);
`endif
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_short_pulse;
    test_hold_inputs;
    test_reset_mid_frame;
    test_all_ones;
    test_checksum;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 100_000_000, meaning the system clock frequency in Hz, which SHALL be an integer multiple of 1_000_000.
REQ-002 The module SHALL have parameter START_MIN_US, default 18000, meaning the minimum host low pulse in microseconds accepted as a start request; benches MAY override it to shorten simulation.
REQ-003 The module SHALL have port clk, input, 1 bit, the single system clock; all logic SHALL be rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit, an asynchronous, active-low reset.
REQ-005 The module SHALL have ports rh_int, rh_dec, t_int and t_dec, each input, 8 bits, carrying the humidity and temperature bytes to be reported.
REQ-006 The module SHALL have port busy, output, 1 bit, high from start-request acceptance to end of frame.
REQ-007 The module SHALL have port frame_done, output, 1 bit, a one-clk pulse when a frame has completed.
REQ-008 The module SHALL have port state, output, 4 bits, the current FSM state encoding for LED debug.
REQ-009 The module SHALL have port dht11_io, inout, 1 bit, the open-drain bus, driven to 0 or released to high-Z only, never driven to 1.

Function
REQ-010 The module SHALL derive a 1 us tick by counting CLK_HZ/1_000_000 clk cycles; all protocol durations below are counted in ticks with ±1 us tolerance.
REQ-011 The module SHALL sample dht11_io through a 2-flop synchronizer; the FSM SHALL use only the synchronized value.
REQ-012 The FSM SHALL have states IDLE, HOST_LOW, WAIT_REL, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW and DONE.
REQ-013 In IDLE, a synchronized low SHALL cause a transition to HOST_LOW and clear the us counter.
REQ-014 In HOST_LOW, a return to high after a low of fewer than START_MIN_US SHALL cause a return to IDLE with no response.
REQ-015 In HOST_LOW, a return to high after a low of at least START_MIN_US SHALL cause a transition to WAIT_REL, assert busy and latch all four data bytes plus checksum = (rh_int+rh_dec+t_int+t_dec) mod 256.
REQ-016 The module SHALL stay in WAIT_REL for 30 us with the line released, then enter RESP_LOW.
REQ-017 The module SHALL drive the line low for 80 us in RESP_LOW, then release it for 80 us in RESP_HIGH.
REQ-018 The module SHALL send 40 bits MSB-first in the order rh_int, rh_dec, t_int, t_dec, checksum; each bit SHALL be BIT_LOW (driven low 50 us) followed by BIT_HIGH (released 26 us for a 0, 70 us for a 1).
REQ-019 After the 40th bit the module SHALL enter END_LOW (driven low 50 us), then DONE, where it SHALL release the line, pulse frame_done for one clk, deassert busy and return to IDLE on the next clk.
REQ-020 From WAIT_REL through END_LOW the module SHALL ignore the line level, so host activity cannot abort a frame.
REQ-021 Changes on the data inputs after latching SHALL NOT affect the frame in flight.
REQ-022 The module SHALL use a 6-bit bit counter that never wraps past 39, and a us counter wide enough for START_MIN_US that saturates rather than wraps.

Reset
REQ-023 While rst is low, the module SHALL hold the FSM in IDLE, release dht11_io, drive busy=0, frame_done=0 and state=IDLE encoding (4'd0), and clear all counters and latches.
REQ-024 Asserting rst mid-frame SHALL release the line immediately without waiting for a clock edge.
REQ-025 After rst is released, a new start request SHALL be required to begin a frame.

Configuration
REQ-026 With macro DHT11_RESP_ERR_INJ_EN defined, the module SHALL add input err_inject (1 bit), sample it when the bytes are latched, and when it is 1 invert the checksum LSB in the frame.
REQ-027 Without DHT11_RESP_ERR_INJ_EN, the err_inject port SHALL NOT exist and the checksum SHALL always be correct.

Verification
REQ-028 Test: START_MIN_US=100, bytes 55/0/24/0, host low 120 us then release -> 30 us, 80 low, 80 high, then 40 bits 0x37,0x00,0x18,0x00,0x4F, 50 us end low, one frame_done pulse.
REQ-029 Test: host low 60 us (below START_MIN_US=100) -> line never driven, busy stays 0, FSM back in IDLE.
REQ-030 Test: change rh_int from 55 to 99 during BIT_HIGH of bit 3 -> transmitted bytes and checksum still 0x37 and 0x4F.
REQ-031 Test: assert rst during RESP_LOW -> dht11_io goes to Z before the next clk edge, busy=0; a fresh 120 us start produces a complete frame.
REQ-032 Test: with DHT11_RESP_ERR_INJ_EN and err_inject=1, bytes 1/2/3/4 -> checksum sent 0x0B instead of 0x0A.
REQ-033 Test: bytes 255/255/255/255 -> checksum 0xFC (mod 256 wrap); all 1-bits have 70 us high and all 0-bits have 26 us high, within ±1 us.
